// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared encodings for the menu navigator
// Purpose: navigator state encoding and controller button bit positions.
// Ports: none (package).
package ui_pkg;

  typedef enum logic [1:0] {
    UI_SPLASH = 2'b00,
    UI_MENU   = 2'b01,
    UI_APP    = 2'b10
  } ui_state_e;

  // Bit positions inside the {Start, C, B, A, Right, Left, Down, Up} word
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;

endpackage

// File: rtl/ui_button_edge.sv
// rtl/ui_button_edge.sv - press edge detection and Up/Down auto-repeat
// Purpose: registers the previous button word, derives press edges and
//          generates auto-repeat steps for a held Up or Down.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   en       in   advance enable (holds the repeat state when low)
//   buttons  in   8-bit controller word, active-high
//   press    out  8-bit rising-edge vector (combinational)
//   rpt_up   out  auto-repeat step for Up (combinational)
//   rpt_dn   out  auto-repeat step for Down (combinational)
module ui_button_edge
  import ui_pkg::*;
#(
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] buttons,
  output logic [7:0] press,
  output logic       rpt_up,
  output logic       rpt_dn
);

  localparam int CNTW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CNTW-1:0] DELAY_V  = CNTW'(REPEAT_DELAY);
  localparam logic [CNTW-1:0] RELOAD_V = CNTW'(REPEAT_DELAY - REPEAT_RATE);

  logic [7:0]      prev_q, prev_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] cnt_inc;
  logic            dir_dn_q, dir_dn_d;   // direction of the last Up/Down edge
  logic            dir_vld_q, dir_vld_d; // an Up/Down edge has been seen since reset
  logic            up_h, dn_h;

  always_comb begin
    // prev tracks the inputs even when en is low, so a button held across
    // an enable transition never produces an edge.
    prev_d    = buttons;
    press     = buttons & ~prev_q;
    cnt_d     = cnt_q;
    dir_dn_d  = dir_dn_q;
    dir_vld_d = dir_vld_q;
    rpt_up    = 1'b0;
    rpt_dn    = 1'b0;
    up_h      = buttons[BTN_UP];
    dn_h      = buttons[BTN_DOWN];
    cnt_inc   = cnt_q + CNTW'(1);
    if (en) begin
      if (press[BTN_UP] || press[BTN_DOWN]) begin
        cnt_d     = '0;
        // Simultaneous Up and Down edges record Down; both being held clears
        // the counter on the next cycle anyway.
        dir_dn_d  = press[BTN_DOWN];
        dir_vld_d = 1'b1;
      end else if (up_h ^ dn_h) begin
        // Only count the direction that was last pressed; the other one
        // (e.g. a button held through reset) freezes the count.
        if (dir_vld_q && (dn_h == dir_dn_q)) begin
          if (cnt_inc == DELAY_V) begin
            cnt_d  = RELOAD_V;
            rpt_up = up_h;
            rpt_dn = dn_h;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= 8'hFF;
      cnt_q     <= '0;
      dir_dn_q  <= 1'b0;
      dir_vld_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      dir_dn_q  <= dir_dn_d;
      dir_vld_q <= dir_vld_d;
    end
  end

endmodule

// File: rtl/ui_menu_nav.sv
// rtl/ui_menu_nav.sv - generic splash/menu/app navigator with cursor
// Purpose: three-state UI navigator over an N_ITEMS menu with wrap or
//          saturate cursor, selection latch and one-cycle strobes.
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   en            in   advance enable; all state held when low
//   buttons       in   {Start, C, B, A, Right, Left, Down, Up}
//   state         out  00 SPLASH, 01 MENU, 10 APP
//   cursor        out  highlighted menu entry
//   app_id        out  entry latched on selection
//   select_pulse  out  one-cycle strobe on entering APP
//   back_pulse    out  one-cycle strobe on leaving APP
module ui_menu_nav
  import ui_pkg::*;
#(
  parameter int N_ITEMS      = 4,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 8,
  parameter int CW           = $clog2(N_ITEMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    buttons,
  output logic [1:0]    state,
  output logic [CW-1:0] cursor,
  output logic [CW-1:0] app_id,
  output logic          select_pulse,
  output logic          back_pulse
);

  localparam logic [CW-1:0] LAST = CW'(N_ITEMS - 1);

  logic [7:0] press;
  logic       rpt_up, rpt_dn;
  logic       mv_up, mv_dn, sel_key;
  logic       unused_press;

  ui_state_e     state_q, state_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic [CW-1:0] app_id_q, app_id_d;
  logic          select_q, select_d;
  logic          back_q, back_d;

  ui_button_edge #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .buttons(buttons),
    .press  (press),
    .rpt_up (rpt_up),
    .rpt_dn (rpt_dn)
  );

  assign unused_press = ^{press[BTN_LEFT], press[BTN_RIGHT], press[BTN_C]};

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    app_id_d = app_id_q;
    select_d = 1'b0;
    back_d   = 1'b0;
    mv_up    = press[BTN_UP] | rpt_up;
    mv_dn    = press[BTN_DOWN] | rpt_dn;
    sel_key  = press[BTN_A] | press[BTN_START];
    if (en) begin
      case (state_q)
        UI_SPLASH: begin
          if (sel_key) begin
            state_d  = UI_MENU;
            cursor_d = '0;
          end
        end
        UI_MENU: begin
          if (sel_key) begin
            state_d  = UI_APP;
            app_id_d = cursor_q;
            select_d = 1'b1;
          end else if (press[BTN_B]) begin
            state_d = UI_SPLASH;
          end else if (mv_dn && !mv_up) begin
            // Compare against the last entry rather than relying on CW-bit
            // overflow, so non-power-of-two menus wrap correctly.
            if (cursor_q == LAST) cursor_d = (WRAP != 0) ? '0 : LAST;
            else                  cursor_d = cursor_q + CW'(1);
          end else if (mv_up && !mv_dn) begin
            if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST : '0;
            else                cursor_d = cursor_q - CW'(1);
          end
        end
        UI_APP: begin
          if (press[BTN_B]) begin
            state_d = UI_MENU;
            back_d  = 1'b1;
          end
        end
        default: state_d = UI_SPLASH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= UI_SPLASH;
      cursor_q <= '0;
      app_id_q <= '0;
      select_q <= 1'b0;
      back_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      app_id_q <= app_id_d;
      select_q <= select_d;
      back_q   <= back_d;
    end
  end

  assign state        = state_q;
  assign cursor       = cursor_q;
  assign app_id       = app_id_q;
  assign select_pulse = select_q;
  assign back_pulse   = back_q;

endmodule

// File: tb/tb_ui_menu_nav.sv
// tb/tb_ui_menu_nav.sv - self-checking bench for ui_menu_nav
module tb_ui_menu_nav;

  localparam int RD = 24;
  localparam int RR = 8;

  // Reference state: held = enabled cycles a direction has been held since
  // its edge; repeats fall at held = RD, RD+RR, RD+2RR, ...
  typedef struct packed {
    logic [7:0] prev;
    int         held;
    int         last;  // 0 none, 1 Up, 2 Down
    int         st;
    int         cur;
    int         app;
    logic       sel;
    logic       back;
  } m_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] buttons;

  logic [1:0] st_a, st_b, st_c;
  logic [1:0] cur_a, app_a;
  logic [2:0] cur_b, app_b, cur_c, app_c;
  logic       sel_a, sel_b, sel_c, back_a, back_b, back_c;

  int         n_cmp = 0;
  int         n_err = 0;
  m_t         m [3];
  int         nn [3];
  bit         ww [3];
  logic [19:0] obs [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ui_menu_nav #(.N_ITEMS(4), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
    .clk(clk), .rst(rst), .en(en), .buttons(buttons), .state(st_a), .cursor(cur_a),
    .app_id(app_a), .select_pulse(sel_a), .back_pulse(back_a));
  ui_menu_nav #(.N_ITEMS(5), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
    .clk(clk), .rst(rst), .en(en), .buttons(buttons), .state(st_b), .cursor(cur_b),
    .app_id(app_b), .select_pulse(sel_b), .back_pulse(back_b));
  ui_menu_nav #(.N_ITEMS(5), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_c (
    .clk(clk), .rst(rst), .en(en), .buttons(buttons), .state(st_c), .cursor(cur_c),
    .app_id(app_c), .select_pulse(sel_c), .back_pulse(back_c));

  always_comb begin
    obs[0] = {st_a, 8'(cur_a), 8'(app_a), sel_a, back_a};
    obs[1] = {st_b, 8'(cur_b), 8'(app_b), sel_b, back_b};
    obs[2] = {st_c, 8'(cur_c), 8'(app_c), sel_c, back_c};
  end

  function automatic m_t m_reset();
    m_t r;
    r.prev = 8'hFF; r.held = 0; r.last = 0; r.st = 0; r.cur = 0; r.app = 0;
    r.sel = 1'b0; r.back = 1'b0;
    return r;
  endfunction

  function automatic m_t step(input m_t s, input logic [7:0] b, input logic e,
                              input int n, input bit wrap);
    m_t r;
    logic [7:0] p;
    bit u, d, ru, rd, mu, md, go;
    r = s;
    p = b & ~s.prev;
    u = b[0]; d = b[1]; ru = 1'b0; rd = 1'b0;
    r.prev = b; r.sel = 1'b0; r.back = 1'b0;
    if (e) begin
      if (p[0] || p[1]) begin
        r.held = 0;
        r.last = p[1] ? 2 : 1;
      end else if (u != d) begin
        if ((d && s.last == 2) || (u && s.last == 1)) begin
          r.held = s.held + 1;
          if (r.held >= RD && (r.held - RD) % RR == 0) begin ru = u; rd = d; end
        end
      end else begin
        r.held = 0;
      end
      mu = p[0] | ru; md = p[1] | rd; go = p[4] | p[7];
      case (s.st)
        0: if (go) begin r.st = 1; r.cur = 0; end
        1: begin
          if (go) begin r.st = 2; r.app = s.cur; r.sel = 1'b1; end
          else if (p[5]) r.st = 0;
          else if (md && !mu) r.cur = wrap ? (s.cur + 1) % n : ((s.cur + 1 < n) ? s.cur + 1 : n - 1);
          else if (mu && !md) r.cur = wrap ? (s.cur + n - 1) % n : ((s.cur > 0) ? s.cur - 1 : 0);
        end
        default: if (p[5]) begin r.st = 1; r.back = 1'b1; end
      endcase
    end
    return r;
  endfunction

  function automatic logic [19:0] exp_of(input m_t s);
    return {2'(s.st), 8'(s.cur), 8'(s.app), s.sel, s.back};
  endfunction

  task automatic tick();
    for (int i = 0; i < 3; i++) if (rst) m[i] = step(m[i], buttons, en, nn[i], ww[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; buttons = 8'h80;
    for (int i = 0; i < 3; i++) m[i] = m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL reset_values dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
    end
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (st_a !== 2'b00) begin n_err++; $display("FAIL start_held_through_reset state got %b expected 00", st_a); end
    buttons = 8'h00; tick();
    buttons = 8'h80; tick();
    n_cmp++;
    if (st_a !== 2'b01 || cur_a !== 2'd0) begin n_err++; $display("FAIL splash_to_menu state/cursor got %b/%0d expected 01/0", st_a, cur_a); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL splash_to_menu dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
    end
    buttons = 8'h00; tick();
  endtask

  task automatic test_wrap();
    buttons = 8'h01; tick();
    n_cmp++;
    if (cur_b !== 3'd4 || cur_c !== 3'd0) begin n_err++; $display("FAIL up_at_zero wrap/sat got %0d/%0d expected 4/0", cur_b, cur_c); end
    buttons = 8'h00; tick();
    buttons = 8'h02; tick();
    n_cmp++;
    if (cur_b !== 3'd0) begin n_err++; $display("FAIL down_at_last_wrap got %0d expected 0", cur_b); end
    buttons = 8'h00; tick();
    for (int k = 0; k < 4; k++) begin
      buttons = 8'h02; tick();
      buttons = 8'h00; tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL down_steps dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
      end
    end
    n_cmp++;
    if (cur_c !== 3'd4 || cur_b !== 3'd4 || cur_a !== 2'd0) begin
      n_err++; $display("FAIL down_saturate a/b/c got %0d/%0d/%0d expected 0/4/4", cur_a, cur_b, cur_c);
    end
  endtask

  task automatic test_repeat();
    int steps[$];
    int exp_steps[5];
    logic [2:0] pc;
    exp_steps = '{0, 24, 32, 40, 48};
    buttons = 8'h20; tick();
    buttons = 8'h00; tick();
    buttons = 8'h80; tick();
    buttons = 8'h00; tick();
    pc = cur_b;
    buttons = 8'h02;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (cur_b !== pc) steps.push_back(t);
      pc = cur_b;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL hold_down t=%0d dut%0d got %h expected %h", t, i, obs[i], exp_of(m[i])); end
      end
    end
    n_cmp++;
    if (steps.size() != 5) begin
      n_err++; $display("FAIL repeat_count got %0d steps expected 5", steps.size());
    end else begin
      for (int k = 0; k < 5; k++)
        if (steps[k] != exp_steps[k]) begin
          n_err++; $display("FAIL repeat_timing step %0d got cycle %0d expected %0d", k, steps[k], exp_steps[k]);
          break;
        end
    end
    n_cmp++;
    if (cur_a !== 2'd1 || cur_b !== 3'd0 || cur_c !== 3'd4) begin
      n_err++; $display("FAIL hold_down_final a/b/c got %0d/%0d/%0d expected 1/0/4", cur_a, cur_b, cur_c);
    end
    buttons = 8'h00; tick();
  endtask

  task automatic test_select_back();
    buttons = 8'h02; tick();
    buttons = 8'h00; tick();
    buttons = 8'h30; tick();
    n_cmp++;
    if (st_a !== 2'b10 || app_a !== 2'd2 || sel_a !== 1'b1 || back_a !== 1'b0) begin
      n_err++; $display("FAIL select_a_and_b state/app/sel/back got %b/%0d/%b/%b expected 10/2/1/0", st_a, app_a, sel_a, back_a);
    end
    buttons = 8'h00; tick();
    n_cmp++;
    if (sel_a !== 1'b0 || st_a !== 2'b10) begin n_err++; $display("FAIL select_pulse_width sel/state got %b/%b expected 0/10", sel_a, st_a); end
    buttons = 8'h20; tick();
    n_cmp++;
    if (st_a !== 2'b01 || cur_a !== 2'd2 || back_a !== 1'b1 || sel_a !== 1'b0) begin
      n_err++; $display("FAIL back_to_menu state/cursor/back/sel got %b/%0d/%b/%b expected 01/2/1/0", st_a, cur_a, back_a, sel_a);
    end
    buttons = 8'h00; tick();
    n_cmp++;
    if (back_a !== 1'b0) begin n_err++; $display("FAIL back_pulse_width got %b expected 0", back_a); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL select_back dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
    end
  endtask

  task automatic test_enable();
    buttons = 8'h03; tick();
    n_cmp++;
    if (cur_a !== 2'd2) begin n_err++; $display("FAIL up_down_together got %0d expected 2", cur_a); end
    buttons = 8'h00; tick();
    en = 1'b0; buttons = 8'h02;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_cmp++;
      if (cur_a !== 2'd2 || st_a !== 2'b01) begin n_err++; $display("FAIL en_low_hold t=%0d cursor/state got %0d/%b expected 2/01", t, cur_a, st_a); end
    end
    en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL en_raise_held t=%0d dut%0d got %h expected %h", t, i, obs[i], exp_of(m[i])); end
      end
    end
    n_cmp++;
    if (cur_a !== 2'd2) begin n_err++; $display("FAIL en_raise_no_move got %0d expected 2", cur_a); end
    buttons = 8'h00; tick();
  endtask

  task automatic test_app_hold();
    buttons = 8'h10; tick();
    buttons = 8'h00; tick();
    buttons = 8'h02;
    for (int t = 0; t < 31; t++) begin
      tick();
      n_cmp++;
      if (st_a !== 2'b10 || cur_a !== 2'd2 || app_a !== 2'd2) begin
        n_err++; $display("FAIL app_ignores_down t=%0d state/cursor/app got %b/%0d/%0d expected 10/2/2", t, st_a, cur_a, app_a);
      end
    end
    buttons = 8'h00; tick();
    buttons = 8'h20; tick();
    buttons = 8'h00; tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL app_exit dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
    end
  endtask

  task automatic test_reset_midhold();
    buttons = 8'h02;
    repeat (3) tick();
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL async_reset dut%0d got %h expected %h", i, obs[i], exp_of(m[i])); end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    buttons = 8'h12; tick();
    buttons = 8'h02;
    for (int t = 0; t < 30; t++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL held_after_reset t=%0d dut%0d got %h expected %h", t, i, obs[i], exp_of(m[i])); end
      end
    end
    n_cmp++;
    if (st_a !== 2'b01 || cur_a !== 2'd0 || cur_b !== 3'd0) begin
      n_err++; $display("FAIL held_after_reset_final state/a/b got %b/%0d/%0d expected 01/0/0", st_a, cur_a, cur_b);
    end
    buttons = 8'h00; tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, (k < 2) ? 31 : 7) == 0) buttons[k] = ~buttons[k];
      en = ($urandom_range(0, 9) != 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== exp_of(m[i])) begin n_err++; $display("FAIL random t=%0d dut%0d got %h expected %h", t, i, obs[i], exp_of(m[i])); end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    nn[0] = 4; nn[1] = 5; nn[2] = 5;
    ww[0] = 1'b1; ww[1] = 1'b1; ww[2] = 1'b0;
    test_reset();
    test_wrap();
    test_repeat();
    test_select_back();
    test_enable();
    test_app_hold();
    test_reset_midhold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
